// File: rtl/ysyx_210978_mul_pkg.sv
// Shared types and constants for the iterative radix-4 Booth multiplier.
package ysyx_210978_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // Booth group counts: 66-bit multiplier for 64-bit ops, 34-bit for MULW.
    localparam int unsigned MUL_ITER_D = 33;
    localparam int unsigned MUL_ITER_W = 17;

    localparam int unsigned PP_W  = 129;
    localparam int unsigned ACC_W = 128;

endpackage

// File: rtl/ysyx_210978_booth_pmgen.sv
// Radix-4 Booth partial-product generator: maps one 3-bit window onto
// {0, +x, +2x, -x, -2x}, sign-extended to the full partial-product width.
module ysyx_210978_booth_pmgen
    import ysyx_210978_mul_pkg::*;
(
    input  logic [2:0]      y_in,
    input  logic [64:0]     x_in,
    output logic [PP_W-1:0] p
);

    logic [PP_W-1:0] x_ext;

    assign x_ext = {{(PP_W - 65){x_in[64]}}, x_in};

    always_comb begin
        p = '0;
        unique case (y_in)
            3'b000, 3'b111: p = '0;
            3'b001, 3'b010: p = x_ext;
            3'b011:         p = x_ext << 1;
            3'b100:         p = -(x_ext << 1);
            3'b101, 3'b110: p = -x_ext;
            default:        p = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_210978_booth_mul_iter.sv
// Iterative radix-4 Booth multiplier for RV64M MUL/MULH/MULHSU/MULHU/MULW:
// one Booth group per cycle accumulated into a 128-bit product.
module ysyx_210978_booth_mul_iter
    import ysyx_210978_mul_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            mul_valid,
    output logic            mul_ready,
    input  logic            flush,
    input  logic            mulw,
    input  logic [1:0]      mul_signed,
    input  logic [XLEN-1:0] multiplicand,
    input  logic [XLEN-1:0] multiplier,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result_hi,
    output logic [XLEN-1:0] result_lo
);

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [XLEN:0]    x_q, x_d;
    logic [XLEN+1:0]  y_q, y_d;
    logic             mulw_q, mulw_d;

    logic [XLEN-1:0]  a_src, b_src;
    logic             a_sgn, b_sgn;
    logic [XLEN+2:0]  y_win_src;
    logic [2:0]       y_in;
    logic [PP_W-1:0]  pp;
    logic [ACC_W-1:0] pp_shift;
    logic [CNT_W:0]   shamt;
    logic [CNT_W-1:0] cnt_last;
    logic             unused_pp_msb;

    // MULW narrows both operands to signed 32-bit before extension.
    always_comb begin
        if (mulw) begin
            a_src = {{(XLEN / 2){multiplicand[XLEN/2-1]}}, multiplicand[XLEN/2-1:0]};
            b_src = {{(XLEN / 2){multiplier[XLEN/2-1]}}, multiplier[XLEN/2-1:0]};
            a_sgn = 1'b1;
            b_sgn = 1'b1;
        end else begin
            a_src = multiplicand;
            b_src = multiplier;
            a_sgn = mul_signed[1];
            b_sgn = mul_signed[0];
        end
    end

    // Window k covers {y[2k+1], y[2k], y[2k-1]} with an implicit y[-1] = 0.
    assign y_win_src = {y_q, 1'b0};
    assign y_in      = y_win_src[{cnt_q, 1'b0} +: 3];

    ysyx_210978_booth_pmgen u_pmgen (
        .y_in (y_in),
        .x_in (x_q),
        .p    (pp)
    );

    assign shamt         = {cnt_q, 1'b0};
    assign pp_shift      = pp[ACC_W-1:0] << shamt;
    assign unused_pp_msb = pp[PP_W-1];
    assign cnt_last      = mulw_q ? CNT_W'(MUL_ITER_W - 1) : CNT_W'(MUL_ITER_D - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        x_d     = x_q;
        y_d     = y_q;
        mulw_d  = mulw_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mul_valid) begin
                        x_d     = {a_sgn & a_src[XLEN-1], a_src};
                        y_d     = {{2{b_sgn & b_src[XLEN-1]}}, b_src};
                        mulw_d  = mulw;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    // Wrap modulo 2^128 is the intended product arithmetic.
                    acc_d = acc_q + pp_shift;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == cnt_last) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            mulw_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mulw_q  <= mulw_d;
        end
    end

    assign mul_ready = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    // Results are only exposed in DONE so partial sums never leak out.
    always_comb begin
        result_hi = '0;
        result_lo = '0;
        if (state_q == DONE) begin
            result_hi = acc_q[ACC_W-1:XLEN];
            result_lo = mulw_q ? {{(XLEN / 2){acc_q[XLEN/2-1]}}, acc_q[XLEN/2-1:0]}
                               : acc_q[XLEN-1:0];
        end
    end

endmodule

// File: tb/tb_ysyx_210978_booth_mul_iter.sv
// Self-checking bench: arithmetic product model plus cycle-level handshake
// model, checked every cycle, with directed literal vectors on top.
module tb_ysyx_210978_booth_mul_iter;

    logic        clock = 1'b0;
    logic        reset;
    logic        mul_valid;
    logic        mul_ready;
    logic        flush;
    logic        mulw;
    logic [1:0]  mul_signed;
    logic [63:0] multiplicand;
    logic [63:0] multiplier;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result_hi;
    logic [63:0] result_lo;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model state
    bit          m_idle  = 1'b1;
    bit          m_valid = 1'b0;
    int          m_left  = 0;
    logic [63:0] p_hi    = '0;
    logic [63:0] p_lo    = '0;

    always #5 clock = ~clock;

    ysyx_210978_booth_mul_iter #(
        .XLEN  (64),
        .CNT_W (6)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mul_valid    (mul_valid),
        .mul_ready    (mul_ready),
        .flush        (flush),
        .mulw         (mulw),
        .mul_signed   (mul_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result_hi    (result_hi),
        .result_lo    (result_lo)
    );

    function automatic logic [127:0] ref_prod(input logic [63:0] a, input logic [63:0] b,
                                              input logic [1:0] sg, input logic w);
        logic [127:0] ea;
        logic [127:0] eb;
        if (w) begin
            ea = {{96{a[31]}}, a[31:0]};
            eb = {{96{b[31]}}, b[31:0]};
        end else begin
            ea = {{64{sg[1] & a[63]}}, a};
            eb = {{64{sg[0] & b[63]}}, b};
        end
        return ea * eb;
    endfunction

    function automatic logic [63:0] ref_hi(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] sg, input logic w);
        logic [127:0] p;
        p = ref_prod(a, b, sg, w);
        return p[127:64];
    endfunction

    function automatic logic [63:0] ref_lo(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] sg, input logic w);
        logic [127:0] p;
        p = ref_prod(a, b, sg, w);
        return w ? {{32{p[31]}}, p[31:0]} : p[63:0];
    endfunction

    always @(posedge clock) begin
        if (reset || flush) begin
            m_idle  <= 1'b1;
            m_valid <= 1'b0;
            m_left  <= 0;
        end else if (m_idle) begin
            if (mul_valid) begin
                m_idle <= 1'b0;
                m_left <= mulw ? 17 : 33;
                p_hi   <= ref_hi(multiplicand, multiplier, mul_signed, mulw);
                p_lo   <= ref_lo(multiplicand, multiplier, mul_signed, mulw);
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_valid <= 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
            m_idle  <= 1'b1;
        end
    end

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check64("cyc out_valid", 64'(out_valid), 64'(m_valid));
            check64("cyc mul_ready", 64'(mul_ready), 64'(m_idle));
            if (m_valid) begin
                check64("cyc result_hi", result_hi, p_hi);
                check64("cyc result_lo", result_lo, p_lo);
            end
        end
    end

    task automatic issue(input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] sg, input logic w);
        @(posedge clock);
        #1;
        multiplicand = a;
        multiplier   = b;
        mul_signed   = sg;
        mulw         = w;
        mul_valid    = 1'b1;
        @(posedge clock);
        #1;
        mul_valid = 1'b0;
    endtask

    // Returns at the negedge of the first out_valid cycle (or after the bound).
    task automatic wait_valid(input string name, input int exp_lat);
        int lat   = 0;
        bit seen  = 1'b0;
        bit rdy_hi = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            if (out_valid) begin
                lat  = i;
                seen = 1'b1;
                break;
            end
            if (mul_ready) rdy_hi = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: no out_valid within 100 cycles", name);
        end else begin
            check_int({name, " latency"}, lat, exp_lat);
            check_int({name, " mul_ready while busy"}, int'(rdy_hi), 0);
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] sg, input logic w,
                          input logic [63:0] exp_hi, input logic [63:0] exp_lo,
                          input int exp_lat);
        issue(a, b, sg, w);
        wait_valid(name, exp_lat);
        check64({name, " hi"}, result_hi, exp_hi);
        check64({name, " lo"}, result_lo, exp_lo);
        accept();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [63:0] hold_hi;
        logic [63:0] hold_lo;
        int          bad;
        reset        = 1'b1;
        mul_valid    = 1'b0;
        flush        = 1'b0;
        mulw         = 1'b0;
        mul_signed   = 2'b00;
        multiplicand = '0;
        multiplier   = '0;
        out_ready    = 1'b0;

        @(posedge clock);
        #1;
        chk_en = 1'b1;
        @(negedge clock);
        check64("reset out_valid", 64'(out_valid), 64'd0);
        check64("reset mul_ready", 64'(mul_ready), 64'd1);
        check64("reset hi", result_hi, 64'd0);
        check64("reset lo", result_lo, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        run_op("mulhu 3*5", 64'd3, 64'd5, 2'b00, 1'b0, 64'd0, 64'hF, 34);
        run_op("mulh -1*-1", '1, '1, 2'b11, 1'b0, 64'd0, 64'd1, 34);
        run_op("mulhu max*max", '1, '1, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 34);
        run_op("mulhsu -1*2", '1, 64'd2, 2'b10, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 34);
        run_op("mulh min*-1", 64'h8000_0000_0000_0000, '1, 2'b11, 1'b0,
               64'd0, 64'h8000_0000_0000_0000, 34);
        run_op("mulw 7fffffff*2", 64'h7FFF_FFFF, 64'd2, 2'b00, 1'b1,
               64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 18);
        run_op("mulw garbage", 64'hDEAD_0000_0000_0003, 64'd4, 2'b00, 1'b1,
               64'd0, 64'hC, 18);
        run_op("mulw -3*5", 64'h0000_0000_FFFF_FFFD, 64'd5, 2'b00, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1, 18);

        // Backpressure with a new request already pending during DONE.
        issue(64'h1_0000_0000, 64'h1_0000_0000, 2'b00, 1'b0);
        wait_valid("bp", 34);
        check64("bp hi", result_hi, 64'd1);
        check64("bp lo", result_lo, 64'd0);
        hold_hi      = result_hi;
        hold_lo      = result_lo;
        multiplicand = 64'd6;
        multiplier   = 64'd7;
        mul_signed   = 2'b00;
        mulw         = 1'b0;
        mul_valid    = 1'b1;
        bad          = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (!out_valid || mul_ready || result_hi !== hold_hi || result_lo !== hold_lo)
                bad++;
        end
        check_int("bp hold stable", bad, 0);
        accept();
        @(negedge clock);
        check64("bp ready after accept", 64'(mul_ready), 64'd1);
        @(posedge clock);
        #1;
        mul_valid = 1'b0;
        wait_valid("b2b 6*7", 34);
        check64("b2b hi", result_hi, 64'd0);
        check64("b2b lo", result_lo, 64'd42);
        accept();

        // Flush mid-op with a competing request.
        issue(64'd3, 64'd5, 2'b00, 1'b0);
        repeat (9) @(posedge clock);
        #1;
        flush     = 1'b1;
        mul_valid = 1'b1;
        @(posedge clock);
        #1;
        flush     = 1'b0;
        mul_valid = 1'b0;
        @(negedge clock);
        check64("flush mul_ready", 64'(mul_ready), 64'd1);
        check64("flush out_valid", 64'(out_valid), 64'd0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (out_valid || !mul_ready) bad++;
        end
        check_int("flush stays idle", bad, 0);
        run_op("after flush 7*9", 64'd7, 64'd9, 2'b00, 1'b0, 64'd0, 64'd63, 34);

        // Reset mid-op.
        issue(64'd3, 64'd5, 2'b00, 1'b0);
        repeat (9) @(posedge clock);
        #1;
        reset     = 1'b1;
        mul_valid = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        check64("midreset out_valid", 64'(out_valid), 64'd0);
        check64("midreset hi", result_hi, 64'd0);
        check64("midreset lo", result_lo, 64'd0);
        check64("midreset mul_ready", 64'(mul_ready), 64'd1);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        mul_valid = 1'b0;
        run_op("after reset 7*9", 64'd7, 64'd9, 2'b00, 1'b0, 64'd0, 64'd63, 34);

        repeat (3) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_210978_booth_mul_iter.md
Name: ysyx_210978_booth_mul_iter

Overview:
Iterative radix-4 Booth multiplier for RV64M MUL/MULH/MULHSU/MULHU/MULW, sitting in the EXU beside the ALU. Each BUSY cycle it slices one 3-bit Booth window from the multiplier and feeds it to the shared partial-product generator. It then accumulates the returned 129-bit partial product, shifted by 2*k. Valid/ready on both sides; flush from pipeline control.

Parameters:
XLEN, 64, operand width (only 64 supported)
CNT_W, 6, iteration counter width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
mul_valid  in  1  request valid
mul_ready  out  1  can accept (high only in IDLE)
flush  in  1  abort current op, synchronous
mulw  in  1  32-bit word op
mul_signed  in  2  {multiplicand signed, multiplier signed}: 11 MULH, 10 MULHSU, 00 MULHU/MUL
multiplicand  in  64  rs1
multiplier  in  64  rs2
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result_hi  out  64  product[127:64]
result_lo  out  64  product[63:0] (MULW: sext of product[31:0])

Behaviour:
- Reset, active-high and synchronous on clock: state=IDLE, cnt=0, acc=0, mul_ready=1, out_valid=0, result_hi=0, result_lo=0.
- States are IDLE, BUSY and DONE.
- IDLE -> BUSY on mul_valid&mul_ready (cycle T). Latch:
  - x = 65-bit extend of multiplicand (sign if mul_signed[1], else zero).
  - y = 66-bit extend of multiplier (sign if mul_signed[0], else zero), with an implicit y[-1]=0.
  - N = 33, or N = 17 when mulw. When mulw, operands are first sign-extended from bit 31 and mul_signed is treated as 11.
  - acc=0, cnt=0.
- BUSY, one group per cycle:
  - y_in = {y[2k+1], y[2k], y[2k-1]} with k=cnt.
  - acc <= acc + (p << 2k)[127:0], where p is the 129-bit pmgen output. Mod-2^128 wrap is intended.
  - cnt++. When cnt==N-1, go to DONE.
- BUSY cycles are T+1..T+N. out_valid=1 from T+N+1, i.e. latency 34 for 64-bit and 18 for MULW.
- DONE:
  - result_hi=acc[127:64]. result_lo=acc[63:0], or {32{acc[31]}, acc[31:0]} for MULW.
  - Outputs are held stable while out_valid&!out_ready.
  - On out_valid&out_ready go to IDLE; mul_ready=1 the next cycle. There is no same-cycle result+accept bypass.
- flush, any state: next state IDLE, out_valid=0, acc and cnt cleared. flush overrides a simultaneous mul_valid and out_ready.
- reset mid-BUSY behaves like flush plus the output clear.
- mul_valid in BUSY or DONE is ignored; operands are not re-sampled.
- Zero operands still take the full N cycles; there is no early termination.

Decomposition:
- Package ysyx_210978_mul_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - constants MUL_ITER_D=33, MUL_ITER_W=17.
  - localparams PP_W=129 and ACC_W=128.
- One sub-module: instantiate the existing ysyx_210978_booth_pmgen (y_in[2:0], x_in[64:0], p[128:0]) once. The rest (window mux, shifter, 128-bit adder, FSM) stays inline.

Test Plan:
- MULHU path, signed=00, rs1=3, rs2=5 -> at T+34 out_valid=1, hi=0, lo=0xF. Confirm mul_ready=0 during T+1..T+34.
- signed=11, rs1=rs2=0xFFFF_FFFF_FFFF_FFFF (-1*-1) -> hi=0, lo=1. With signed=00 and the same operands -> hi=0xFFFF_FFFF_FFFF_FFFE, lo=0x1.
- signed=10, rs1=-1, rs2=2 -> hi=0xFFFF_FFFF_FFFF_FFFF, lo=0xFFFF_FFFF_FFFF_FFFE. Also signed=11 with rs1=0x8000_0000_0000_0000 and rs2=-1 -> hi=0, lo=0x8000_0000_0000_0000.
- mulw=1, rs1=0x7FFF_FFFF, rs2=2 -> out_valid at T+18, lo=0xFFFF_FFFF_FFFF_FFFE. Upper operand garbage such as rs1=0xDEAD_0000_0000_0003, rs2=4 -> lo=0xC.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable and mul_ready=0. Pulse out_ready, then a back-to-back second op is accepted exactly one cycle later.
- flush at cycle T+10 of a 64-bit op, with mul_valid also high -> IDLE next cycle, no out_valid. A following 7*9 returns lo=63. Repeat the check with reset asserted at T+10: all outputs are 0.
